nco_lut_scheduler: RTL and testbench

- Two-channel NCO sequencer sharing one 16-entry, 8-bit, 1-cycle-latency synchronous sine LUT.
- Each channel has a phase accumulator. A channel's sample-rate tick raises a request, and a round-robin arbiter grants the LUT to one channel per cycle.
- The returned LUT word is routed to the granted channel's output register with a valid pulse.
- Sits between the carrier/tone timing logic and the 1-bit AM modulator datapath.

---
 rtl/nco_lut_scheduler.sv | 179 +++++++++++++++++
 tb/tb_nco_lut_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_lut_scheduler.sv
// Two-channel NCO sequencer sharing one 1-cycle-latency synchronous sine LUT through a round-robin arbiter.
// Optional: define NCO_LUT_SCHED_OVR_CNT_EN to add per-channel saturating overrun counters on ovr_cnt.
module nco_lut_scheduler #(
   parameter int PHASE_W = 16,
   parameter int LUT_AW  = 4,
   parameter int DATA_W  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ch0_en,
   input  logic [PHASE_W-1:0] ch0_ftw,
   input  logic               ch0_tick,
   output logic [DATA_W-1:0]  ch0_sample,
   output logic               ch0_valid,
   input  logic               ch1_en,
   input  logic [PHASE_W-1:0] ch1_ftw,
   input  logic               ch1_tick,
   output logic [DATA_W-1:0]  ch1_sample,
   output logic               ch1_valid,
   input  logic               ovr_clr,
   output logic [1:0]         ch_overrun,
   output logic [LUT_AW-1:0]  lut_addr,
   input  logic [DATA_W-1:0]  lut_data,
   output logic               busy
`ifdef NCO_LUT_SCHED_OVR_CNT_EN
   ,
   output logic [15:0]        ovr_cnt
`endif
);

   logic [1:0]         en;
   logic [1:0]         tick;
   logic [1:0]         pend;
   logic [1:0]         req;
   logic [1:0]         gnt;
   logic [1:0]         ovr_ev;
   logic [1:0]         ovr_q;
   logic [1:0]         s1_sel;
   logic [1:0]         s2_sel;
   logic [1:0]         valid_q;
   logic               last_gnt;
   logic [LUT_AW-1:0]  addr_q;
   logic [PHASE_W-1:0] gnt_phase;
   logic [PHASE_W-1:0] phase    [2];
   logic [PHASE_W-1:0] ftw      [2];
   logic [DATA_W-1:0]  sample_q [2];

   assign en     = {ch1_en, ch0_en};
   assign tick   = {ch1_tick, ch0_tick};
   assign ftw[0] = ch0_ftw;
   assign ftw[1] = ch1_ftw;

   // A disabled channel never competes, so a grant never collides with its phase reset.
   assign req = pend & en;

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   assign gnt_phase = gnt[1] ? phase[1] : phase[0];
   assign ovr_ev    = en & tick & pend & ~gnt;

   // Request capture and phase accumulation; a tick coinciding with a grant re-arms the request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < 2; n++) begin
            pend[n]  <= 1'b0;
            phase[n] <= '0;
         end
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (!en[n]) begin
               pend[n]  <= 1'b0;
               phase[n] <= '0;
            end else begin
               if (tick[n]) begin
                  pend[n] <= 1'b1;
               end else if (gnt[n]) begin
                  pend[n] <= 1'b0;
               end
               if (gnt[n]) begin
                  phase[n] <= phase[n] + ftw[n];
               end
            end
         end
      end
   end

   // last_gnt resets to channel 1 so channel 0 wins the first contested cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt <= 1'b1;
         addr_q   <= '0;
         s1_sel   <= 2'b00;
         s2_sel   <= 2'b00;
      end else begin
         if (|gnt) begin
            last_gnt <= gnt[1];
            addr_q   <= gnt_phase[PHASE_W-1 -: LUT_AW];
         end
         s1_sel <= gnt;
         s2_sel <= s1_sel;
      end
   end

   // Output contract: chN_valid is high for exactly one cycle, in which chN_sample
   // already holds the new word; there is no back-pressure, so consumers must accept it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 2'b00;
         for (int n = 0; n < 2; n++) begin
            sample_q[n] <= '0;
         end
      end else begin
         valid_q <= s2_sel;
         for (int n = 0; n < 2; n++) begin
            if (s2_sel[n]) begin
               sample_q[n] <= lut_data;
            end
         end
      end
   end

   // A fresh overrun beats a coincident clear so no event is silently lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovr_q <= 2'b00;
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (ovr_ev[n]) begin
               ovr_q[n] <= 1'b1;
            end else if (ovr_clr) begin
               ovr_q[n] <= 1'b0;
            end
         end
      end
   end

`ifdef NCO_LUT_SCHED_OVR_CNT_EN
   logic [7:0] ovr_cnt_q [2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < 2; n++) begin
            ovr_cnt_q[n] <= '0;
         end
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (ovr_ev[n]) begin
               if (ovr_clr) begin
                  ovr_cnt_q[n] <= 8'd1;
               end else if (ovr_cnt_q[n] != 8'hFF) begin
                  ovr_cnt_q[n] <= ovr_cnt_q[n] + 8'd1;
               end
            end else if (ovr_clr) begin
               ovr_cnt_q[n] <= '0;
            end
         end
      end
   end

   assign ovr_cnt = {ovr_cnt_q[1], ovr_cnt_q[0]};
`endif

   assign ch0_sample = sample_q[0];
   assign ch1_sample = sample_q[1];
   assign ch0_valid  = valid_q[0];
   assign ch1_valid  = valid_q[1];
   assign ch_overrun = ovr_q;
   assign lut_addr   = addr_q;
   assign busy       = (|pend) | (|s1_sel) | (|s2_sel);

endmodule

// File: tb/tb_nco_lut_scheduler.sv
// Scoreboard bench for nco_lut_scheduler: a cycle-level reference model predicts samples, flags and addresses.
// Build with NCO_LUT_SCHED_OVR_CNT_EN defined to also check the overrun counters.
module tb_nco_lut_scheduler;

   localparam int PHASE_W = 16;
   localparam int LUT_AW  = 4;
   localparam int DATA_W  = 8;

   // clock / reset / DUT
   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               ch0_en = 1'b0, ch1_en = 1'b0;
   logic               ch0_tick = 1'b0, ch1_tick = 1'b0;
   logic [PHASE_W-1:0] ch0_ftw = '0, ch1_ftw = '0;
   logic [DATA_W-1:0]  ch0_sample, ch1_sample;
   logic               ch0_valid, ch1_valid;
   logic               ovr_clr = 1'b0;
   logic [1:0]         ch_overrun;
   logic [LUT_AW-1:0]  lut_addr;
   logic [DATA_W-1:0]  lut_data = '0;
   logic               busy;
`ifdef NCO_LUT_SCHED_OVR_CNT_EN
   logic [15:0]        ovr_cnt;
`endif

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   nco_lut_scheduler #(.PHASE_W(PHASE_W), .LUT_AW(LUT_AW), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .ch0_en(ch0_en), .ch0_ftw(ch0_ftw), .ch0_tick(ch0_tick),
      .ch0_sample(ch0_sample), .ch0_valid(ch0_valid),
      .ch1_en(ch1_en), .ch1_ftw(ch1_ftw), .ch1_tick(ch1_tick),
      .ch1_sample(ch1_sample), .ch1_valid(ch1_valid),
      .ovr_clr(ovr_clr), .ch_overrun(ch_overrun),
      .lut_addr(lut_addr), .lut_data(lut_data), .busy(busy)
`ifdef NCO_LUT_SCHED_OVR_CNT_EN
      , .ovr_cnt(ovr_cnt)
`endif
   );

   // external sine ROM, one cycle read latency
   logic [7:0] sine [16] = '{8'h00, 8'h30, 8'h59, 8'h75, 8'h7F, 8'h75, 8'h59, 8'h30,
                              8'h00, 8'hD0, 8'hA7, 8'h8B, 8'h81, 8'h8B, 8'hA7, 8'hD0};
   always @(posedge clk) lut_data <= sine[lut_addr];

   // scoreboard
   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] q0 [$];
   logic [31:0] q1 [$];
   logic [31:0] st_q [$];
`ifdef NCO_LUT_SCHED_OVR_CNT_EN
   logic [31:0] cnt_q [$];
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // reference model state
   logic [1:0]         m_pend;
   logic [1:0]         m_ovr;
   logic [PHASE_W-1:0] m_phase [2];
   int                 m_last;
   logic               m_gprev;
   logic [3:0]         m_addr;
`ifdef NCO_LUT_SCHED_OVR_CNT_EN
   logic [7:0]         m_cnt [2];
`endif

   task automatic model_init();
      m_pend = 2'b00;
      m_ovr = 2'b00;
      m_phase[0] = '0;
      m_phase[1] = '0;
      m_last = 1;
      m_gprev = 1'b0;
      m_addr = '0;
`ifdef NCO_LUT_SCHED_OVR_CNT_EN
      m_cnt[0] = '0;
      m_cnt[1] = '0;
`endif
   endtask

   // Predicts the effect of the upcoming rising edge from the inputs just driven.
   task automatic model_step();
      logic [1:0]         en_v, tk, req, ev;
      logic [PHASE_W-1:0] f [2];
      logic [3:0]         a;
      logic               busy_e;
      int                 g;
      en_v = {ch1_en, ch0_en};
      tk = {ch1_tick, ch0_tick};
      f[0] = ch0_ftw;
      f[1] = ch1_ftw;
      req = m_pend & en_v;
      g = -1;
      if (req == 2'b11) g = (m_last == 0) ? 1 : 0;
      else if (req[0]) g = 0;
      else if (req[1]) g = 1;
      if (g >= 0) begin
         a = m_phase[g][PHASE_W-1 -: LUT_AW];
         m_addr = a;
         if (g == 0) q0.push_back({24'(cyc + 3), sine[a]});
         else        q1.push_back({24'(cyc + 3), sine[a]});
         m_phase[g] = m_phase[g] + f[g];
         m_last = g;
      end
      for (int n = 0; n < 2; n++) begin
         ev[n] = en_v[n] && tk[n] && m_pend[n] && (g != n);
         if (ev[n]) m_ovr[n] = 1'b1;
         else if (ovr_clr) m_ovr[n] = 1'b0;
`ifdef NCO_LUT_SCHED_OVR_CNT_EN
         if (ev[n]) m_cnt[n] = ovr_clr ? 8'd1 : ((m_cnt[n] == 8'hFF) ? 8'hFF : m_cnt[n] + 8'd1);
         else if (ovr_clr) m_cnt[n] = 8'd0;
`endif
         if (!en_v[n]) begin
            m_pend[n] = 1'b0;
            m_phase[n] = '0;
         end else if (tk[n]) begin
            m_pend[n] = 1'b1;
         end else if (g == n) begin
            m_pend[n] = 1'b0;
         end
      end
      busy_e = (m_pend != 2'b00) || (g >= 0) || m_gprev;
      m_gprev = (g >= 0);
      st_q.push_back({24'(cyc + 1), 1'b0, m_ovr, busy_e, m_addr});
`ifdef NCO_LUT_SCHED_OVR_CNT_EN
      cnt_q.push_back({16'(cyc + 1), m_cnt[1], m_cnt[0]});
`endif
   endtask

   // driver
   logic               nx_en0 = 1'b0, nx_en1 = 1'b0;
   logic [PHASE_W-1:0] nx_ftw0 = '0, nx_ftw1 = '0;

   task automatic step(input logic t0, input logic t1, input logic clr);
      @(negedge clk);
      ch0_en = nx_en0;
      ch1_en = nx_en1;
      ch0_ftw = nx_ftw0;
      ch1_ftw = nx_ftw1;
      ch0_tick = t0;
      ch1_tick = t1;
      ovr_clr = clr;
      model_step();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs",
            32'({ch0_sample, ch1_sample, ch0_valid, ch1_valid, ch_overrun, lut_addr, busy}), 32'd0);
      q0.delete();
      q1.delete();
      st_q.delete();
`ifdef NCO_LUT_SCHED_OVR_CNT_EN
      cnt_q.delete();
`endif
      model_init();
      repeat (2) @(negedge clk);
      ch0_tick = 1'b0;
      ch1_tick = 1'b0;
      ovr_clr = 1'b0;
      ch0_en = nx_en0;
      ch1_en = nx_en1;
      ch0_ftw = nx_ftw0;
      ch1_ftw = nx_ftw1;
      rst_n = 1'b1;
      model_step();
   endtask

   // monitor
   logic [7:0]  hold0 = '0, hold1 = '0;
   logic [31:0] e;

   always begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
         hold0 = '0;
         hold1 = '0;
         check("reset_outputs",
               32'({ch0_sample, ch1_sample, ch0_valid, ch1_valid, ch_overrun, lut_addr, busy}), 32'd0);
      end else begin
         if (q0.size() > 0 && q0[0][31:8] == 24'(cyc)) begin
            e = q0.pop_front();
            hold0 = e[7:0];
            check("ch0_valid", 32'(ch0_valid), 32'd1);
         end else begin
            check("ch0_valid", 32'(ch0_valid), 32'd0);
         end
         check("ch0_sample", 32'(ch0_sample), 32'(hold0));
         if (q1.size() > 0 && q1[0][31:8] == 24'(cyc)) begin
            e = q1.pop_front();
            hold1 = e[7:0];
            check("ch1_valid", 32'(ch1_valid), 32'd1);
         end else begin
            check("ch1_valid", 32'(ch1_valid), 32'd0);
         end
         check("ch1_sample", 32'(ch1_sample), 32'(hold1));
         if (st_q.size() > 0 && st_q[0][31:8] == 24'(cyc)) begin
            e = st_q.pop_front();
            check("ch_overrun", 32'(ch_overrun), 32'(e[6:5]));
            check("busy", 32'(busy), 32'(e[4]));
            check("lut_addr", 32'(lut_addr), 32'(e[3:0]));
         end
`ifdef NCO_LUT_SCHED_OVR_CNT_EN
         if (cnt_q.size() > 0 && cnt_q[0][31:16] == 16'(cyc)) begin
            e = cnt_q.pop_front();
            check("ovr_cnt", 32'(ovr_cnt), 32'(e[15:0]));
         end
`endif
      end
   end

   // stimulus
   initial begin
      model_init();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_step();

      // ramp through the whole table at ftw 0x1000, tick every 4 cycles
      nx_en0 = 1'b1;
      nx_ftw0 = 16'h1000;
      for (int i = 0; i < 17; i++) begin
         step(1'b1, 1'b0, 1'b0);
         repeat (3) step(1'b0, 1'b0, 1'b0);
      end

      // both channels saturated: alternating grants
      do_reset();
      nx_en1 = 1'b1;
      nx_ftw0 = 16'h4000;
      nx_ftw1 = 16'hC000;
      repeat (8) step(1'b1, 1'b1, 1'b0);
      repeat (4) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);

      // ch0 overrun while ch1 holds priority, then stickiness, clear and saturation
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      repeat (5) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      repeat (3) step(1'b0, 1'b0, 1'b0);
      repeat (700) step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      repeat (4) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);

      // descending phase with wrap
      do_reset();
      nx_en1 = 1'b0;
      nx_ftw0 = 16'hF000;
      for (int i = 0; i < 18; i++) begin
         step(1'b1, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b0);
      end
      repeat (3) step(1'b0, 1'b0, 1'b0);

      // reset while a read is in flight
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      repeat (4) step(1'b0, 1'b0, 1'b0);

      // ch1 disable right after a grant, then re-enable
      nx_en1 = 1'b1;
      nx_ftw1 = 16'h1000;
      repeat (2) begin
         step(1'b0, 1'b1, 1'b0);
         repeat (3) step(1'b0, 1'b0, 1'b0);
      end
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      nx_en1 = 1'b0;
      repeat (4) step(1'b0, 1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0);
      nx_en1 = 1'b1;
      step(1'b0, 1'b1, 1'b0);
      repeat (4) step(1'b0, 1'b0, 1'b0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         nx_en0 = ($urandom_range(0, 9) != 0);
         nx_en1 = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 15) == 0) nx_ftw0 = 16'($urandom);
         if ($urandom_range(0, 15) == 0) nx_ftw1 = 16'($urandom);
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
      end

      // drain, bounded
      for (int i = 0; i < 20 && (q0.size() + q1.size()) > 0; i++) step(1'b0, 1'b0, 1'b0);
      check("drain_pending_samples", 32'(q0.size() + q1.size()), 32'd0);
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
